slow_clock_monitor: RTL and testbench



---
 rtl/slow_clock_monitor.sv | 145 ++++++++++++++
 tb/tb_slow_clock_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clock_monitor.sv
// Watches a divided clock sampled on `clock`: measures its period, flags lock after a
// run of identical periods and flags a stall when edges stop. Define SLOW_CLOCK_MONITOR_DUTY_EN for high_time.

module slow_clock_monitor #(
    parameter int Width     = 8,
    parameter int LockCount = 4,
    parameter int Timeout   = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inclock,
    output logic             rise,
    output logic             fall,
    output logic [Width-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled
`ifdef SLOW_CLOCK_MONITOR_DUTY_EN
    ,
    output logic [Width-1:0] high_time
`endif
);

    localparam int                MatchW   = $clog2(LockCount + 1);
    localparam logic [MatchW-1:0] LockV    = MatchW'(LockCount);
    localparam logic [Width-1:0]  TimeoutV = Width'(Timeout);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, STALL} state_t;

    state_t              state, state_n;
    logic                in_q, primed;
    logic [Width-1:0]    cnt, new_period;
    logic [Width-1:0]    ref_period, ref_n;
    logic                have_ref, have_ref_n;
    logic [MatchW-1:0]   match, match_n, match_inc;
    logic                rise_det, fall_det, timed_out, same, publish;

    // primed masks the first sample after reset so a level held through reset is not an edge
    assign rise_det   = primed & inclock & ~in_q;
    assign fall_det   = primed & ~inclock & in_q;
    assign new_period = cnt + Width'(1);
    assign timed_out  = (cnt == TimeoutV);
    assign same       = have_ref && (new_period == ref_period);
    assign match_inc  = (match >= LockV) ? match : match + MatchW'(1);

    always_comb begin
        state_n    = state;
        ref_n      = ref_period;
        have_ref_n = have_ref;
        match_n    = match;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                if (rise_det)       state_n = MEASURE;
                else if (timed_out) state_n = STALL;
            end
            MEASURE: begin
                if (rise_det) begin
                    publish = 1'b1;
                    if (same) begin
                        match_n = match_inc;
                    end else begin
                        ref_n      = new_period;
                        have_ref_n = 1'b1;
                        match_n    = MatchW'(1);
                    end
                    if (match_n >= LockV) state_n = LOCKED;
                end else if (timed_out) begin
                    state_n = STALL;
                end
            end
            LOCKED: begin
                if (rise_det) begin
                    publish = 1'b1;
                    if (!same) begin
                        ref_n   = new_period;
                        match_n = MatchW'(1);
                        state_n = MEASURE;
                    end
                end else if (timed_out) begin
                    state_n = STALL;
                end
            end
            STALL: begin
                // the saturated count says nothing about the real period, so start over
                if (rise_det) begin
                    have_ref_n = 1'b0;
                    match_n    = '0;
                    state_n    = MEASURE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            in_q         <= 1'b0;
            primed       <= 1'b0;
            cnt          <= '0;
            ref_period   <= '0;
            have_ref     <= 1'b0;
            match        <= '0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            state        <= state_n;
            in_q         <= inclock;
            primed       <= 1'b1;
            ref_period   <= ref_n;
            have_ref     <= have_ref_n;
            match        <= match_n;
            rise         <= rise_det;
            fall         <= fall_det;
            period_valid <= publish;
            locked       <= (state_n == LOCKED);
            stalled      <= (state_n == STALL);
            if (publish) period <= new_period;
            if (rise_det)       cnt <= '0;
            else if (!timed_out) cnt <= cnt + Width'(1);
        end
    end

`ifdef SLOW_CLOCK_MONITOR_DUTY_EN
    logic [Width-1:0] hcnt;

    // high-phase counter spans one rise-to-rise window and is captured alongside period
    always_ff @(posedge clock) begin
        if (reset) begin
            hcnt      <= '0;
            high_time <= '0;
        end else begin
            if (rise_det)                  hcnt <= '0;
            else if (in_q && (hcnt != '1)) hcnt <= hcnt + Width'(1);
            if (publish) high_time <= hcnt;
        end
    end
`endif

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Bench for slow_clock_monitor: two instances (default and LockCount=1/Timeout=20) share one
// inclock stream; a gap/run-length model is compared every cycle, plus hand-computed checkpoints.

module tb_slow_clock_monitor;

    logic       clock;
    logic       reset;
    logic       inclock;
    logic       rise_o[2];
    logic       fall_o[2];
    logic [7:0] period_o[2];
    logic       pv_o[2];
    logic       locked_o[2];
    logic       stalled_o[2];
`ifdef SLOW_CLOCK_MONITOR_DUTY_EN
    logic [7:0] high_o[2];
`endif

    int vectors     = 0;
    int miscompares = 0;
    int fail_prints = 0;

    slow_clock_monitor dut_a (
        .clock(clock), .reset(reset), .inclock(inclock),
        .rise(rise_o[0]), .fall(fall_o[0]), .period(period_o[0]),
        .period_valid(pv_o[0]), .locked(locked_o[0]), .stalled(stalled_o[0])
`ifdef SLOW_CLOCK_MONITOR_DUTY_EN
        , .high_time(high_o[0])
`endif
    );

    slow_clock_monitor #(.Width(8), .LockCount(1), .Timeout(20)) dut_b (
        .clock(clock), .reset(reset), .inclock(inclock),
        .rise(rise_o[1]), .fall(fall_o[1]), .period(period_o[1]),
        .period_valid(pv_o[1]), .locked(locked_o[1]), .stalled(stalled_o[1])
`ifdef SLOW_CLOCK_MONITOR_DUTY_EN
        , .high_time(high_o[1])
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
            end
        end
    endtask

    // Model: each instance tracked by edges since the last rise, the run of equal periods,
    // and whether the current segment (since reset/stall) has seen a rise yet.
    int         lock_count[2] = '{4, 1};
    int         timeout[2]    = '{255, 20};
    bit         started = 1'b0;
    bit         prev_known[2], prev_s[2], seg[2];
    int         since[2], highs[2], run[2], lastp[2];
    bit         m_rise[2], m_fall[2], m_pv[2], m_locked[2], m_stalled[2];
    logic [7:0] m_period[2], m_high[2];

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                prev_known[i] = 0; prev_s[i] = 0; seg[i] = 0;
                since[i] = 0; highs[i] = 0; run[i] = 0; lastp[i] = 0;
                m_rise[i] = 0; m_fall[i] = 0; m_pv[i] = 0;
                m_locked[i] = 0; m_stalled[i] = 0; m_period[i] = 0; m_high[i] = 0;
            end else begin : model_step
                bit r, f, changed;
                int gap;
                r   = prev_known[i] && inclock && !prev_s[i];
                f   = prev_known[i] && !inclock && prev_s[i];
                gap = since[i] + 1;
                m_pv[i] = 0;
                if (r) begin
                    if (seg[i]) begin
                        m_pv[i]     = 1;
                        m_period[i] = 8'(gap);
                        m_high[i]   = (highs[i] > 255) ? 8'd255 : 8'(highs[i]);
                        changed     = (run[i] == 0) || (gap != lastp[i]);
                        run[i]      = changed ? 1 : run[i] + 1;
                        lastp[i]    = gap;
                        m_locked[i] = (run[i] >= lock_count[i]) && !(m_locked[i] && changed);
                    end
                    seg[i] = 1; m_stalled[i] = 0; since[i] = 0; highs[i] = 1;
                end else begin
                    since[i] = gap;
                    highs[i] = highs[i] + int'(inclock);
                    if (gap >= timeout[i] + 1 && !m_stalled[i]) begin
                        m_stalled[i] = 1; m_locked[i] = 0; seg[i] = 0; run[i] = 0;
                    end
                end
                m_rise[i] = r; m_fall[i] = f;
                prev_s[i] = inclock; prev_known[i] = 1;
            end
        end
        if (reset) started = 1'b1;
    end

    always @(negedge clock) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("dut%0d.rise", i),         32'(rise_o[i]),    32'(m_rise[i]));
                checkOutput($sformatf("dut%0d.fall", i),         32'(fall_o[i]),    32'(m_fall[i]));
                checkOutput($sformatf("dut%0d.period", i),       32'(period_o[i]),  32'(m_period[i]));
                checkOutput($sformatf("dut%0d.period_valid", i), 32'(pv_o[i]),      32'(m_pv[i]));
                checkOutput($sformatf("dut%0d.locked", i),       32'(locked_o[i]),  32'(m_locked[i]));
                checkOutput($sformatf("dut%0d.stalled", i),      32'(stalled_o[i]), 32'(m_stalled[i]));
`ifdef SLOW_CLOCK_MONITOR_DUTY_EN
                checkOutput($sformatf("dut%0d.high_time", i),    32'(high_o[i]),    32'(m_high[i]));
`endif
            end
        end
    end

    task automatic applyStimulus(input logic level, input int n);
        inclock = level;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulseReset(input logic level);
        reset   = 1'b1;
        inclock = level;
        @(negedge clock);
        reset   = 1'b0;
    endtask

    task automatic square(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, hi);
            applyStimulus(1'b0, lo);
        end
    endtask

    initial begin
        reset   = 1'b1;
        inclock = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("reset.period", 32'(period_o[0]), 0);
        checkOutput("reset.locked", 32'(locked_o[0]), 0);
        checkOutput("reset.stalled", 32'(stalled_o[0]), 0);

        // 4 high / 4 low: first rise publishes nothing, lock on the 4th published period
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 1);
        checkOutput("first.rise", 32'(rise_o[0]), 1);
        checkOutput("first.period_valid", 32'(pv_o[0]), 0);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 4);
        square(4, 4, 3);
        checkOutput("prelock.locked", 32'(locked_o[0]), 0);
        checkOutput("b.lock1.locked", 32'(locked_o[1]), 1);
        applyStimulus(1'b1, 1);
        checkOutput("lock4.period", 32'(period_o[0]), 8);
        checkOutput("lock4.period_valid", 32'(pv_o[0]), 1);
        checkOutput("lock4.locked", 32'(locked_o[0]), 1);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 4);
        square(4, 4, 2);

        // stretched low phase: period 10, unlock, relock after four periods of 8
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 6);
        applyStimulus(1'b1, 1);
        checkOutput("stretch.period", 32'(period_o[0]), 10);
        checkOutput("stretch.locked", 32'(locked_o[0]), 0);
        checkOutput("b.stretch.locked", 32'(locked_o[1]), 0);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 4);
        square(4, 4, 3);
        checkOutput("relock3.locked", 32'(locked_o[0]), 0);
        applyStimulus(1'b1, 1);
        checkOutput("relock4.locked", 32'(locked_o[0]), 1);
        applyStimulus(1'b1, 3);

        // hold low: 255 rise-free cycles, stall on the next
        applyStimulus(1'b0, 252);
        checkOutput("prestall.stalled", 32'(stalled_o[0]), 0);
        applyStimulus(1'b0, 1);
        checkOutput("stall.stalled", 32'(stalled_o[0]), 1);
        checkOutput("stall.locked", 32'(locked_o[0]), 0);
        applyStimulus(1'b0, 40);
        applyStimulus(1'b1, 1);
        checkOutput("unstall.rise", 32'(rise_o[0]), 1);
        checkOutput("unstall.period_valid", 32'(pv_o[0]), 0);
        checkOutput("unstall.stalled", 32'(stalled_o[0]), 0);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 4);
        square(4, 4, 7);

        // one-cycle reset in the middle of a high phase
        applyStimulus(1'b1, 2);
        pulseReset(1'b1);
        checkOutput("rst.rise", 32'(rise_o[0]), 0);
        checkOutput("rst.period", 32'(period_o[0]), 0);
        checkOutput("rst.locked", 32'(locked_o[0]), 0);
        checkOutput("b.rst.locked", 32'(locked_o[1]), 0);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 1);
        checkOutput("rst.rise1.period_valid", 32'(pv_o[0]), 0);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 1);
        checkOutput("rst.rise2.period_valid", 32'(pv_o[0]), 1);
        checkOutput("rst.rise2.period", 32'(period_o[0]), 8);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 4);

        // period 16 locks the LockCount=1 instance; period 24 stalls it after 20 idle cycles
        square(8, 8, 4);
        checkOutput("b.p16.locked", 32'(locked_o[1]), 1);
        checkOutput("b.p16.period", 32'(period_o[1]), 16);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 9);
        checkOutput("b.p24.idle20.stalled", 32'(stalled_o[1]), 0);
        applyStimulus(1'b0, 1);
        checkOutput("b.p24.idle21.stalled", 32'(stalled_o[1]), 1);
        applyStimulus(1'b0, 2);
        square(12, 12, 2);

        // 3 high / 5 low duty pattern
        square(3, 5, 6);
        checkOutput("duty.period", 32'(period_o[0]), 8);
`ifdef SLOW_CLOCK_MONITOR_DUTY_EN
        checkOutput("duty.high_time", 32'(high_o[0]), 3);
`endif
        applyStimulus(1'b0, 5);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
